// File: rtl/maple_pkg.sv
// rtl/maple_pkg.sv - Shared state encodings and bus-select constants for the Maple transmit path.
package maple_pkg;

    typedef enum logic [6:0] {
        ST_IDLE  = 7'b0000001,
        ST_START = 7'b0000010,
        ST_FETCH = 7'b0000100,
        ST_SEND  = 7'b0001000,
        ST_CRC   = 7'b0010000,
        ST_END   = 7'b0100000,
        ST_DONE  = 7'b1000000
    } maple_state_t;

    localparam logic [1:0] BUS_SEL_NONE  = 2'b00;
    localparam logic [1:0] BUS_SEL_START = 2'b01;
    localparam logic [1:0] BUS_SEL_DATA  = 2'b10;
    localparam logic [1:0] BUS_SEL_END   = 2'b11;

    localparam int MAPLE_MAX_WORDS = 256;
    localparam int WORDS_W         = $clog2(MAPLE_MAX_WORDS) + 1;

endpackage

// File: rtl/maple_word_unpacker.sv
// rtl/maple_word_unpacker.sv - Splits a 32-bit word into MSB-first bytes and keeps the running XOR checksum.
module maple_word_unpacker (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_clear,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic        send_en,
    input  logic        crc_sel,
    input  logic        byte_ready,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    output logic        byte_fire,
    output logic        last_byte
);

    logic [31:0] word_q;
    logic [1:0]  byte_idx;
    logic [7:0]  crc_q;
    logic [7:0]  word_byte;
    logic        data_fire;

    always_comb begin
        word_byte = word_q[31:24];
        case (byte_idx)
            2'd0: word_byte = word_q[31:24];
            2'd1: word_byte = word_q[23:16];
            2'd2: word_byte = word_q[15:8];
            2'd3: word_byte = word_q[7:0];
            default: word_byte = word_q[31:24];
        endcase
    end

    assign byte_data  = crc_sel ? crc_q : word_byte;
    assign byte_valid = send_en;
    assign byte_fire  = send_en && byte_ready;
    assign last_byte  = (byte_idx == 2'd3);
    assign data_fire  = byte_fire && !crc_sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            word_q   <= 32'h0;
            byte_idx <= 2'd0;
            crc_q    <= 8'h0;
        end else begin
            if (frame_clear) begin
                crc_q <= 8'h0;
            end else if (data_fire) begin
                crc_q <= crc_q ^ word_byte;
            end
            if (load) begin
                word_q   <= load_data;
                byte_idx <= 2'd0;
            end else if (data_fire) begin
                byte_idx <= byte_idx + 2'd1;
            end
        end
    end

endmodule

// File: rtl/maple_tx_frame_sequencer.sv
// rtl/maple_tx_frame_sequencer.sv - Maple port transmit frame sequencer: start, data bytes, checksum, end.
module maple_tx_frame_sequencer
    import maple_pkg::*;
#(
    parameter int TIMEOUT = 4096,
    parameter int TO_W    = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tx_start,
    input  logic [7:0]  tx_len,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        tx_err,
    input  logic [31:0] word_data,
    input  logic        word_valid,
    output logic        word_ready,
    output logic        start_en,
    input  logic        start_done,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        end_en,
    input  logic        end_done,
    output logic [1:0]  bus_sel,
    output logic        bus_oe
);

    maple_state_t        state;
    maple_state_t        state_next;
    logic                entry_q;
    logic [WORDS_W-1:0]  words_left;
    logic [TO_W-1:0]     to_cnt;
    logic                counting;
    logic                timeout;
    logic                word_fire;
    logic                send_en;
    logic                byte_fire;
    logic                last_byte;
    logic                accept;

    assign counting  = (state == ST_START) || (state == ST_SEND) ||
                       (state == ST_CRC)   || (state == ST_END);
    assign timeout   = counting && (to_cnt == TO_W'(TIMEOUT - 1));
    assign word_fire = (state == ST_FETCH) && word_valid;
    assign send_en   = ((state == ST_SEND) || (state == ST_CRC)) && !timeout;
    assign accept    = (state == ST_IDLE) && tx_start;
    assign tx_busy   = (state != ST_IDLE);

    maple_word_unpacker u_unpacker (
        .clk         (clk),
        .reset       (reset),
        .frame_clear (accept),
        .load        (word_fire),
        .load_data   (word_data),
        .send_en     (send_en),
        .crc_sel     (state == ST_CRC),
        .byte_ready  (byte_ready),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .byte_fire   (byte_fire),
        .last_byte   (last_byte)
    );

    always_comb begin
        state_next = state;
        tx_done    = 1'b0;
        tx_err     = 1'b0;
        start_en   = 1'b0;
        end_en     = 1'b0;
        word_ready = 1'b0;
        bus_sel    = BUS_SEL_NONE;
        bus_oe     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tx_start) state_next = ST_START;
            end
            ST_START: begin
                start_en = entry_q;
                bus_sel  = BUS_SEL_START;
                bus_oe   = 1'b1;
                if (start_done) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                word_ready = 1'b1;
                bus_sel    = BUS_SEL_DATA;
                bus_oe     = 1'b1;
                if (word_valid) state_next = ST_SEND;
            end
            ST_SEND: begin
                bus_sel = BUS_SEL_DATA;
                bus_oe  = 1'b1;
                if (byte_fire && last_byte)
                    state_next = (words_left == WORDS_W'(1)) ? ST_CRC : ST_FETCH;
            end
            ST_CRC: begin
                bus_sel = BUS_SEL_DATA;
                bus_oe  = 1'b1;
                if (byte_fire) state_next = ST_END;
            end
            ST_END: begin
                end_en  = entry_q;
                bus_sel = BUS_SEL_END;
                bus_oe  = 1'b1;
                if (end_done) state_next = ST_DONE;
            end
            ST_DONE: begin
                tx_done    = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        // A stuck encoder releases the lines immediately and abandons the frame.
        if (timeout) begin
            state_next = ST_IDLE;
            tx_err     = 1'b1;
            start_en   = 1'b0;
            end_en     = 1'b0;
            bus_sel    = BUS_SEL_NONE;
            bus_oe     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            entry_q    <= 1'b0;
            words_left <= '0;
            to_cnt     <= '0;
        end else begin
            state   <= state_next;
            entry_q <= (state_next != state);
            if (accept)
                words_left <= WORDS_W'(tx_len) + WORDS_W'(1);
            else if ((state == ST_SEND) && byte_fire && last_byte)
                words_left <= words_left - WORDS_W'(1);
            if ((state_next != state) || byte_fire || word_fire || !counting)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + TO_W'(1);
        end
    end

endmodule

// File: tb/tb_maple_tx_frame_sequencer.sv
// tb/tb_maple_tx_frame_sequencer.sv - Directed self-checking bench for maple_tx_frame_sequencer.
module tb_maple_tx_frame_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tx_start = 1'b0;
    logic [7:0]  tx_len = 8'h0;
    logic        tx_busy, tx_done, tx_err;
    logic [31:0] word_data = 32'h0;
    logic        word_valid = 1'b0;
    logic        word_ready;
    logic        start_en;
    logic        start_done = 1'b0;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready = 1'b0;
    logic        end_en;
    logic        end_done = 1'b0;
    logic [1:0]  bus_sel;
    logic        bus_oe;

    maple_tx_frame_sequencer #(.TIMEOUT(4096), .TO_W(12)) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_start   (tx_start),
        .tx_len     (tx_len),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_err     (tx_err),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .start_en   (start_en),
        .start_done (start_done),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .end_en     (end_en),
        .end_done   (end_done),
        .bus_sel    (bus_sel),
        .bus_oe     (bus_oe)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    int          n_done = 0;
    int          n_errp = 0;
    logic [7:0]  byte_log[$];
    logic [1:0]  sel_log[$];
    logic [31:0] wq[$];
    logic [7:0]  e[$];
    bit          host_en = 1'b1;
    bit          start_resp = 1'b1;
    bit          byte_stall = 1'b0;
    int          resp_delay = 5;
    int          byte_delay = 5;
    int          start_cnt = 0;
    int          end_cnt = 0;
    int          bcnt = 0;
    bit          w_pend = 1'b0;
    logic [1:0]  last_sel = 2'b00;

    // Encoder and host models, plus logging of every byte handshake and bus_sel change.
    always @(negedge clk) begin
        if (tx_done) n_done++;
        if (tx_err) n_errp++;
        if (bus_sel !== last_sel) begin
            sel_log.push_back(bus_sel);
            last_sel = bus_sel;
        end
        start_done = 1'b0;
        if (start_cnt > 0) begin
            start_cnt--;
            if (start_cnt == 0) start_done = 1'b1;
        end else if (start_en && start_resp) begin
            start_cnt = resp_delay;
        end
        end_done = 1'b0;
        if (end_cnt > 0) begin
            end_cnt--;
            if (end_cnt == 0) end_done = 1'b1;
        end else if (end_en) begin
            end_cnt = resp_delay;
        end
        if (w_pend) begin
            if (wq.size() > 0) wq.delete(0);
            w_pend = 1'b0;
        end
        word_valid = host_en && (wq.size() > 0);
        word_data  = (wq.size() > 0) ? wq[0] : 32'h0;
        if (word_valid && word_ready) w_pend = 1'b1;
        if (byte_ready || !byte_valid) begin
            byte_ready = 1'b0;
            bcnt = 0;
        end else if (!byte_stall) begin
            if (bcnt >= byte_delay) byte_ready = 1'b1;
            else bcnt++;
        end
        if (byte_valid && byte_ready) byte_log.push_back(byte_data);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic add_word(input logic [31:0] w);
        wq.push_back(w);
        e.push_back(w[31:24]);
        e.push_back(w[23:16]);
        e.push_back(w[15:8]);
        e.push_back(w[7:0]);
    endtask

    task automatic clear_logs();
        byte_log.delete();
        sel_log.delete();
        e.delete();
    endtask

    task automatic kick(input string tag, input logic [7:0] len);
        tx_len   = len;
        tx_start = 1'b1;
        tick(1);
        tx_start = 1'b0;
        chk({tag, "_start_en"}, 32'(start_en), 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int c;
        c = 0;
        while (tx_busy && c < budget) begin
            tick(1);
            c++;
        end
        chk({tag, "_idle"}, 32'(tx_busy), 32'd0);
    endtask

    task automatic chk_bytes(input string tag);
        chk({tag, "_count"}, byte_log.size(), e.size());
        for (int i = 0; i < e.size(); i++)
            chk($sformatf("%s_b%0d", tag, i),
                32'((i < byte_log.size()) ? byte_log[i] : 8'hxx), 32'(e[i]));
    endtask

    initial begin
        int          base_done;
        int          base_err;
        int          cyc;
        int          k;
        int          mism;
        bit          stable;
        logic [7:0]  held;
        logic [7:0]  crc;
        logic [31:0] w;
        logic [7:0]  wb [4];

        tick(3);
        chk("reset_outputs", 32'({tx_busy, tx_done, tx_err, word_ready, start_en,
                                  byte_valid, end_en, bus_sel, bus_oe}), 32'd0);
        reset = 1'b0;
        tick(2);

        // Single header word, checksum equals XOR of 01..04.
        clear_logs();
        base_done = n_done;
        add_word(32'h01020304);
        e.push_back(8'h04);
        kick("t1", 8'd0);
        chk("t1_busy", 32'(tx_busy), 32'd1);
        wait_idle("t1", 500);
        chk_bytes("t1");
        chk("t1_done", n_done - base_done, 32'd1);
        chk("t1_err", n_errp, 32'd0);
        chk("t1_sel_n", sel_log.size(), 32'd4);
        chk("t1_sel_seq", 32'({sel_log[0], sel_log[1], sel_log[2], sel_log[3]}), 32'b01_10_11_00);

        // Three words; checksum hand-computed as 0x08.
        clear_logs();
        base_done = n_done;
        add_word(32'hFF000000);
        add_word(32'h00FF0000);
        add_word(32'h12345678);
        e.push_back(8'h08);
        kick("t2", 8'd2);
        wait_idle("t2", 1000);
        chk_bytes("t2");
        chk("t2_done", n_done - base_done, 32'd1);

        // Bit encoder stalls mid-word for 100 cycles.
        clear_logs();
        base_done = n_done;
        base_err  = n_errp;
        wb[0] = 8'hA1; wb[1] = 8'hB2; wb[2] = 8'hC3; wb[3] = 8'hD4;
        add_word(32'hA1B2C3D4);
        e.push_back(8'h04);
        kick("t3", 8'd0);
        cyc = 0;
        while (byte_log.size() < 2 && cyc < 500) begin
            tick(1);
            cyc++;
        end
        byte_stall = 1'b1;
        tick(2);
        k = byte_log.size();
        held = byte_data;
        stable = 1'b1;
        repeat (100) begin
            tick(1);
            if (byte_data !== held || byte_valid !== 1'b1) stable = 1'b0;
        end
        chk("t3_stall_stable", 32'(stable), 32'd1);
        chk("t3_stall_byte", 32'(held), 32'((k < 4) ? wb[k] : 8'hxx));
        chk("t3_stall_no_err", n_errp - base_err, 32'd0);
        byte_stall = 1'b0;
        wait_idle("t3", 500);
        chk_bytes("t3");
        chk("t3_done", n_done - base_done, 32'd1);

        // Host withholds the word for 10000 cycles in FETCH.
        clear_logs();
        base_done = n_done;
        base_err  = n_errp;
        host_en = 1'b0;
        add_word(32'hCAFEF00D);
        e.push_back(8'hC9);
        kick("t4", 8'd0);
        tick(10000);
        chk("t4_fetch_wait", 32'({word_ready, bus_oe, bus_sel}), 32'b1_1_10);
        chk("t4_no_err", n_errp - base_err, 32'd0);
        host_en = 1'b1;
        wait_idle("t4", 500);
        chk_bytes("t4");
        chk("t4_done", n_done - base_done, 32'd1);

        // Start encoder never answers: abort after TIMEOUT cycles in START.
        clear_logs();
        base_done = n_done;
        base_err  = n_errp;
        start_resp = 1'b0;
        add_word(32'h5A5A5A5A);
        e.push_back(8'h00);
        kick("t5", 8'd0);
        cyc = 0;
        while (!tx_err && cyc < 5000) begin
            tick(1);
            cyc++;
        end
        chk("t5_timeout_cycle", cyc, 32'd4095);
        chk("t5_abort_outputs", 32'({tx_err, bus_oe, bus_sel, start_en, byte_valid}), 32'b1_0_00_0_0);
        tick(1);
        chk("t5_idle_after_err", 32'(tx_busy), 32'd0);
        chk("t5_err_pulses", n_errp - base_err, 32'd1);
        chk("t5_no_done", n_done - base_done, 32'd0);
        start_resp = 1'b1;
        base_done = n_done;
        kick("t5b", 8'd0);
        wait_idle("t5b", 500);
        chk_bytes("t5b");
        chk("t5b_done", n_done - base_done, 32'd1);

        // Reset asserted while sending word 3 of 5.
        clear_logs();
        for (int i = 0; i < 5; i++) add_word(32'h10203040 + 32'(i) * 32'h01010101);
        kick("t6", 8'd4);
        cyc = 0;
        while (byte_log.size() < 9 && cyc < 1000) begin
            tick(1);
            cyc++;
        end
        chk("t6_in_send", 32'(byte_valid), 32'd1);
        base_done = n_done;
        base_err  = n_errp;
        reset = 1'b1;
        tick(1);
        chk("t6_reset_outputs", 32'({tx_busy, tx_done, tx_err, word_ready, start_en,
                                     byte_valid, end_en, bus_sel, bus_oe}), 32'd0);
        tick(1);
        reset = 1'b0;
        wq.delete();
        tick(20);
        chk("t6_no_done", n_done - base_done, 32'd0);
        chk("t6_no_err", n_errp - base_err, 32'd0);

        // Maximum length frame with a tx_start pulse while busy.
        clear_logs();
        base_done = n_done;
        byte_delay = 0;
        crc = 8'h00;
        for (int i = 0; i < 256; i++) begin
            w = $urandom;
            add_word(w);
            crc = crc ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
        end
        e.push_back(crc);
        kick("t7", 8'd255);
        tick(50);
        tx_len = 8'd3;
        tx_start = 1'b1;
        tick(1);
        tx_start = 1'b0;
        wait_idle("t7", 6000);
        chk("t7_count", byte_log.size(), 32'd1025);
        mism = 0;
        for (int i = 0; i < e.size(); i++)
            if (i >= byte_log.size() || byte_log[i] !== e[i]) mism++;
        chk("t7_byte_mismatches", mism, 32'd0);
        chk("t7_done", n_done - base_done, 32'd1);
        tick(10);
        chk("t7_busy_start_ignored", 32'(tx_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
